// File: rtl/mxu_tile_sched.sv
// One GEMM pass: preload the first weight tile, stream featuremap rows while the next weight tile loads, drain, done.
// Outputs register one cycle after each issue decision. A high hold suppresses the following cycle's issue and freezes all indices.
module mxu_tile_sched #(
    parameter int SZI          = 8,
    parameter int SZJ          = 8,
    parameter int DIM_W        = 16,
    parameter int ADDR_W       = 20,
    parameter int DRAIN_CYCLES = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_m,
    input  logic [DIM_W-1:0]  cfg_ktiles,
    input  logic [DIM_W-1:0]  cfg_ntiles,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_rd_addr,
    output logic              info_valid,
    output logic              info_new_tile_k,
    output logic              info_first_tile_k,
    output logic              info_last_tile_k
);

    if (SZI < 2 || SZJ < 1) begin : g_bad_params
        $error("mxu_tile_sched: SZI must be >= 2 and SZJ >= 1");
    end

    typedef enum logic [2:0] {IDLE, PRELOAD, STREAM, DRAIN, DONE} state_t;

    localparam logic [DIM_W-1:0]  ONE     = DIM_W'(1);
    localparam logic [DIM_W-1:0]  SZI_D   = DIM_W'(SZI);
    localparam logic [DIM_W-1:0]  DRAIN_L = DIM_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] SZI_A   = ADDR_W'(SZI);

    state_t             state, state_nxt;
    logic [DIM_W-1:0]   m_q, kt_tot, nt_tot, m_nxt, kt_tot_nxt, nt_tot_nxt;
    logic [DIM_W-1:0]   pcnt, pcnt_nxt, kt, kt_nxt, nt, nt_nxt;
    logic [ADDR_W-1:0]  a_base, a_base_nxt, b_base, b_base_nxt;
    logic [DIM_W-1:0]   phase_last;
    logic               kt_last, last_tile;

    logic               busy_nxt, done_nxt, a_en_nxt, b_en_nxt;
    logic [ADDR_W-1:0]  a_addr_nxt, b_addr_nxt;
    logic               vld_nxt, new_k_nxt, first_k_nxt, last_k_nxt;

    // A phase lasts long enough for both the M rows and the SZI-vector weight load.
    assign phase_last = ((m_q > SZI_D) ? m_q : SZI_D) - ONE;
    assign kt_last    = (kt == kt_tot - ONE);
    assign last_tile  = kt_last && (nt == nt_tot - ONE);

    always_comb begin
        state_nxt   = state;
        m_nxt       = m_q;
        kt_tot_nxt  = kt_tot;
        nt_tot_nxt  = nt_tot;
        pcnt_nxt    = pcnt;
        kt_nxt      = kt;
        nt_nxt      = nt;
        a_base_nxt  = a_base;
        b_base_nxt  = b_base;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        a_en_nxt    = 1'b0;
        a_addr_nxt  = '0;
        b_en_nxt    = 1'b0;
        b_addr_nxt  = '0;
        vld_nxt     = 1'b0;
        new_k_nxt   = 1'b0;
        first_k_nxt = 1'b0;
        last_k_nxt  = 1'b0;

        case (state)
            IDLE: begin
                // done is still high in the cycle after DONE; a start there is dropped.
                if (start && !done) begin
                    m_nxt      = cfg_m;
                    kt_tot_nxt = cfg_ktiles;
                    nt_tot_nxt = cfg_ntiles;
                    busy_nxt   = 1'b1;
                    pcnt_nxt   = '0;
                    kt_nxt     = '0;
                    nt_nxt     = '0;
                    a_base_nxt = '0;
                    b_base_nxt = '0;
                    if (cfg_m == '0 || cfg_ktiles == '0 || cfg_ntiles == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = PRELOAD;
                        b_en_nxt  = 1'b1;
                        pcnt_nxt  = ONE;
                    end
                end
            end
            PRELOAD: begin
                if (!hold) begin
                    b_en_nxt   = 1'b1;
                    b_addr_nxt = ADDR_W'(pcnt);
                    if (pcnt == SZI_D - ONE) begin
                        pcnt_nxt  = '0;
                        state_nxt = STREAM;
                    end else begin
                        pcnt_nxt = pcnt + ONE;
                    end
                end
            end
            STREAM: begin
                if (!hold) begin
                    if (pcnt < m_q) begin
                        a_en_nxt    = 1'b1;
                        a_addr_nxt  = a_base + ADDR_W'(pcnt);
                        vld_nxt     = 1'b1;
                        new_k_nxt   = (pcnt == '0);
                        first_k_nxt = (kt == '0);
                        last_k_nxt  = kt_last;
                    end
                    if (pcnt < SZI_D && !last_tile) begin
                        b_en_nxt   = 1'b1;
                        b_addr_nxt = b_base + SZI_A + ADDR_W'(pcnt);
                    end
                    if (pcnt == phase_last) begin
                        pcnt_nxt   = '0;
                        b_base_nxt = b_base + SZI_A;
                        if (last_tile) begin
                            state_nxt = DRAIN;
                        end else if (kt_last) begin
                            kt_nxt     = '0;
                            nt_nxt     = nt + ONE;
                            a_base_nxt = '0;
                        end else begin
                            kt_nxt     = kt + ONE;
                            a_base_nxt = a_base + ADDR_W'(m_q);
                        end
                    end else begin
                        pcnt_nxt = pcnt + ONE;
                    end
                end
            end
            DRAIN: begin
                if (pcnt == DRAIN_L) begin
                    pcnt_nxt  = '0;
                    state_nxt = DONE;
                end else begin
                    pcnt_nxt = pcnt + ONE;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            m_q               <= '0;
            kt_tot            <= '0;
            nt_tot            <= '0;
            pcnt              <= '0;
            kt                <= '0;
            nt                <= '0;
            a_base            <= '0;
            b_base            <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            a_rd_en           <= 1'b0;
            a_rd_addr         <= '0;
            b_rd_en           <= 1'b0;
            b_rd_addr         <= '0;
            info_valid        <= 1'b0;
            info_new_tile_k   <= 1'b0;
            info_first_tile_k <= 1'b0;
            info_last_tile_k  <= 1'b0;
        end else begin
            state             <= state_nxt;
            m_q               <= m_nxt;
            kt_tot            <= kt_tot_nxt;
            nt_tot            <= nt_tot_nxt;
            pcnt              <= pcnt_nxt;
            kt                <= kt_nxt;
            nt                <= nt_nxt;
            a_base            <= a_base_nxt;
            b_base            <= b_base_nxt;
            busy              <= busy_nxt;
            done              <= done_nxt;
            a_rd_en           <= a_en_nxt;
            a_rd_addr         <= a_addr_nxt;
            b_rd_en           <= b_en_nxt;
            b_rd_addr         <= b_addr_nxt;
            info_valid        <= vld_nxt;
            info_new_tile_k   <= new_k_nxt;
            info_first_tile_k <= first_k_nxt;
            info_last_tile_k  <= last_k_nxt;
        end
    end

endmodule

// File: tb/tb_mxu_tile_sched.sv
// Bench for mxu_tile_sched: per-cycle issue slots are predicted into a scoreboard queue and checked as they appear.
module tb_mxu_tile_sched;
    localparam int SZI    = 8;
    localparam int DIM_W  = 16;
    localparam int ADDR_W = 20;
    localparam int DRAIN  = 24;
    localparam int LIMIT  = 2000;

    typedef struct packed {
        logic              a_en;
        logic [ADDR_W-1:0] a_addr;
        logic              b_en;
        logic [ADDR_W-1:0] b_addr;
        logic              vld;
        logic              new_k;
        logic              first_k;
        logic              last_k;
    } slot_t;

    logic              clk = 1'b0;
    logic              reset, start, hold, hold_s;
    logic [DIM_W-1:0]  cfg_m, cfg_ktiles, cfg_ntiles;
    logic              busy, done, a_rd_en, b_rd_en;
    logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
    logic              info_valid, info_new_tile_k, info_first_tile_k, info_last_tile_k;

    int    checks   = 0;
    int    failures = 0;
    bit    mon_on   = 1'b0;
    slot_t slot_q[$];
    slot_t act, expv;

    mxu_tile_sched #(.SZI(SZI), .SZJ(8), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_m(cfg_m), .cfg_ktiles(cfg_ktiles), .cfg_ntiles(cfg_ntiles), .hold(hold),
        .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
        .info_valid(info_valid), .info_new_tile_k(info_new_tile_k),
        .info_first_tile_k(info_first_tile_k), .info_last_tile_k(info_last_tile_k)
    );

    always #5 clk = ~clk;

    always @(posedge clk) hold_s <= hold;

    // Scoreboard: one expected slot per unheld issue cycle; held cycles must be silent.
    always @(negedge clk) begin
        if (mon_on) begin
            act.a_en    = a_rd_en;
            act.a_addr  = a_rd_en ? a_rd_addr : '0;
            act.b_en    = b_rd_en;
            act.b_addr  = b_rd_en ? b_rd_addr : '0;
            act.vld     = info_valid;
            act.new_k   = info_new_tile_k;
            act.first_k = info_first_tile_k;
            act.last_k  = info_last_tile_k;
            checks++;
            if (slot_q.size() == 0) begin
                if (a_rd_en !== 1'b0 || b_rd_en !== 1'b0 || info_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_no_reads: a_rd_en=%b b_rd_en=%b info_valid=%b, expected all 0",
                             a_rd_en, b_rd_en, info_valid);
                end
            end else if (hold_s) begin
                if (act !== '0) begin
                    failures++;
                    $display("FAIL held_slot: got %h, expected 0", act);
                end
            end else begin
                expv = slot_q.pop_front();
                if (act !== expv) begin
                    failures++;
                    $display("FAIL slot: got a=%b/%0d b=%b/%0d tags=%b%b%b%b, expected a=%b/%0d b=%b/%0d tags=%b%b%b%b",
                             act.a_en, act.a_addr, act.b_en, act.b_addr, act.vld, act.new_k, act.first_k, act.last_k,
                             expv.a_en, expv.a_addr, expv.b_en, expv.b_addr, expv.vld, expv.new_k, expv.first_k, expv.last_k);
                end
            end
        end
    end

    task automatic build_exp(input int m, input int kt, input int nt);
        slot_t s;
        int p_len, tile;
        p_len = (m > SZI) ? m : SZI;
        for (int r = 0; r < SZI; r++) begin
            s = '0;
            s.b_en = 1'b1;
            s.b_addr = ADDR_W'(r);
            slot_q.push_back(s);
        end
        tile = 0;
        for (int n = 0; n < nt; n++) begin
            for (int k = 0; k < kt; k++) begin
                for (int p = 0; p < p_len; p++) begin
                    s = '0;
                    if (p < m) begin
                        s.a_en    = 1'b1;
                        s.a_addr  = ADDR_W'(k * m + p);
                        s.vld     = 1'b1;
                        s.new_k   = (p == 0);
                        s.first_k = (k == 0);
                        s.last_k  = (k == kt - 1);
                    end
                    if (p < SZI && !(n == nt - 1 && k == kt - 1)) begin
                        s.b_en   = 1'b1;
                        s.b_addr = ADDR_W'((tile + 1) * SZI + p);
                    end
                    slot_q.push_back(s);
                end
                tile++;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 with cfg scrambled.
    task automatic issue_start(input int m, input int kt, input int nt);
        start = 1'b1;
        cfg_m = DIM_W'(m);
        cfg_ktiles = DIM_W'(kt);
        cfg_ntiles = DIM_W'(nt);
        @(posedge clk);
        build_exp(m, kt, nt);
        mon_on = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_m = DIM_W'($urandom_range(1, 40));
        cfg_ktiles = DIM_W'($urandom_range(1, 5));
        cfg_ntiles = DIM_W'($urandom_range(1, 5));
    endtask

    task automatic wait_done(input int h0, input int hlen, output int cyc);
        cyc = 1;
        forever begin
            hold = (cyc >= h0 && cyc < h0 + hlen);
            if (done === 1'b1 || cyc >= LIMIT) break;
            @(negedge clk);
            cyc++;
        end
        hold = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, a_rd_en, b_rd_en, info_valid, info_new_tile_k, info_first_tile_k, info_last_tile_k} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b a=%b b=%b v=%b, expected all 0",
                     busy, done, a_rd_en, b_rd_en, info_valid);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc;
        issue_start(16, 2, 1);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b, expected 1", busy); end
        wait_done(0, 0, cyc);
        checks++;
        if (cyc != SZI + 2 * 16 + DRAIN + 1) begin
            failures++; $display("FAIL basic_done_cycle: got %0d, expected %0d", cyc, SZI + 32 + DRAIN + 1);
        end
        checks++;
        if (slot_q.size() != 0) begin failures++; $display("FAIL basic_slots_left: got %0d, expected 0", slot_q.size()); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: got %b, expected 0", busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width: got %b, expected 0", done); end
    endtask

    task automatic test_small_m;
        int cyc;
        issue_start(3, 1, 2);
        wait_done(0, 0, cyc);
        checks++;
        if (cyc != SZI + 2 * SZI + DRAIN + 1) begin
            failures++; $display("FAIL small_m_done_cycle: got %0d, expected %0d", cyc, SZI + 2 * SZI + DRAIN + 1);
        end
        checks++;
        if (slot_q.size() != 0) begin failures++; $display("FAIL small_m_slots_left: got %0d, expected 0", slot_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_hold;
        int cyc;
        // Row 7 of (nt=0, kt=1) appears in cycle 32; holding cycles 31..35 freezes it and the B overlap.
        issue_start(16, 2, 2);
        wait_done(31, 5, cyc);
        checks++;
        if (cyc != SZI + 4 * 16 + DRAIN + 1 + 5) begin
            failures++; $display("FAIL hold_done_cycle: got %0d, expected %0d", cyc, SZI + 64 + DRAIN + 6);
        end
        checks++;
        if (slot_q.size() != 0) begin failures++; $display("FAIL hold_slots_left: got %0d, expected 0", slot_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_degenerate;
        start = 1'b1; cfg_m = 16; cfg_ktiles = 0; cfg_ntiles = 1;
        @(posedge clk);
        mon_on = 1'b1;
        @(negedge clk);
        start = 1'b1; cfg_m = 4; cfg_ktiles = 1; cfg_ntiles = 1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL degen_cycle1: busy=%b done=%b, expected 1 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL degen_done: done=%b busy=%b, expected 1 0", done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                failures++; $display("FAIL degen_second_start: busy=%b done=%b, expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_mid_reset;
        int cyc;
        bit saw;
        issue_start(16, 2, 1);
        repeat (14) @(negedge clk);
        mon_on = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        slot_q.delete();
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, a_rd_en, b_rd_en, info_valid, info_new_tile_k, info_first_tile_k, info_last_tile_k} !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b a=%b b=%b v=%b, expected all 0",
                     busy, done, a_rd_en, b_rd_en, info_valid);
        end
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw) begin failures++; $display("FAIL mid_reset_no_done: got activity, expected none"); end
        issue_start(16, 2, 1);
        wait_done(0, 0, cyc);
        checks++;
        if (cyc != SZI + 32 + DRAIN + 1) begin
            failures++; $display("FAIL mid_reset_replay_cycle: got %0d, expected %0d", cyc, SZI + 32 + DRAIN + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue_start(3, 1, 1);
        wait_done(0, 0, cyc);
        checks++;
        if (cyc != SZI + SZI + DRAIN + 1) begin
            failures++; $display("FAIL b2b_first_done: got %0d, expected %0d", cyc, 2 * SZI + DRAIN + 1);
        end
        start = 1'b1; cfg_m = 5; cfg_ktiles = 1; cfg_ntiles = 1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_start_in_done: busy=%b, expected 0", busy); end
        issue_start(10, 2, 1);
        wait_done(0, 0, cyc);
        checks++;
        if (cyc != SZI + 2 * 10 + DRAIN + 1) begin
            failures++; $display("FAIL b2b_second_done: got %0d, expected %0d", cyc, SZI + 20 + DRAIN + 1);
        end
        checks++;
        if (slot_q.size() != 0) begin failures++; $display("FAIL b2b_slots_left: got %0d, expected 0", slot_q.size()); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0;
        cfg_m = '0; cfg_ktiles = '0; cfg_ntiles = '0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_small_m;
        test_hold;
        test_degenerate;
        test_mid_reset;
        test_back_to_back;
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
